// File: rtl/row_stream_scheduler_if.sv
// Row command channel: scheduler offers one row burst, SDRAM controller accepts and reports completion.
interface row_stream_scheduler_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [1:0]  cmd_bank;
    logic [12:0] cmd_row;
    logic        cmd_done;

    modport master (output cmd_valid, cmd_write, cmd_bank, cmd_row,
                    input  cmd_ready, cmd_done);
    modport slave  (input  cmd_valid, cmd_write, cmd_bank, cmd_row,
                    output cmd_ready, cmd_done);
endinterface

// File: rtl/row_stream_scheduler.sv
// Schedules full-row SDRAM write/read bursts between the stream FIFOs and the controller,
// pulses the ring-pointer increments and tracks how many rows SDRAM currently holds.
module row_stream_scheduler #(
    parameter int unsigned ROW_WORDS = 512,
    parameter int unsigned LEVEL_W   = 11,
    parameter int unsigned MAX_ROWS  = 32767
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [LEVEL_W-1:0]     in_level,
    input  logic [LEVEL_W-1:0]     out_free,
    input  logic                   refresh_req,
    input  logic                   sdram_empty,
    input  logic [12:0]            wr_row,
    input  logic [1:0]             wr_bank,
    input  logic [12:0]            rd_row,
    input  logic [1:0]             rd_bank,
    row_stream_scheduler_if.master cmd_if,
    output logic                   incr_wr_ptr,
    output logic                   incr_rd_ptr,
    output logic                   sdram_full,
    output logic [14:0]            rows_stored,
    output logic                   busy
);
    localparam int unsigned ROWS_W = 15;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, ADVANCE, SETTLE} state_e;

    state_e            state_q, state_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              cmd_write_q, cmd_write_d;
    logic [1:0]        cmd_bank_q, cmd_bank_d;
    logic [12:0]       cmd_row_q, cmd_row_d;
    logic              incr_wr_q, incr_wr_d;
    logic              incr_rd_q, incr_rd_d;
    logic [ROWS_W-1:0] rows_q, rows_d;
    logic              sdram_full_q, sdram_full_d;
    logic              last_wr_q, last_wr_d;
    logic              busy_q, busy_d;
    logic              wr_ok, rd_ok, sel_write;

    // Next-state and registered-output logic; incr pulses default low so they last one cycle.
    always_comb begin
        state_d      = state_q;
        cmd_valid_d  = cmd_valid_q;
        cmd_write_d  = cmd_write_q;
        cmd_bank_d   = cmd_bank_q;
        cmd_row_d    = cmd_row_q;
        incr_wr_d    = 1'b0;
        incr_rd_d    = 1'b0;
        rows_d       = rows_q;
        last_wr_d    = last_wr_q;
        wr_ok        = (in_level >= LEVEL_W'(ROW_WORDS)) && !sdram_full_q;
        rd_ok        = (out_free >= LEVEL_W'(ROW_WORDS)) && !sdram_empty;
        // On a tie, take the opposite of the last completed operation.
        sel_write    = wr_ok && (!rd_ok || !last_wr_q);

        case (state_q)
            IDLE: begin
                if (!refresh_req && (wr_ok || rd_ok)) begin
                    cmd_write_d = sel_write;
                    cmd_bank_d  = sel_write ? wr_bank : rd_bank;
                    cmd_row_d   = sel_write ? wr_row : rd_row;
                    cmd_valid_d = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_if.cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (cmd_if.cmd_done) begin
                    incr_wr_d = cmd_write_q;
                    incr_rd_d = !cmd_write_q;
                    rows_d    = cmd_write_q ? rows_q + ROWS_W'(1) : rows_q - ROWS_W'(1);
                    last_wr_d = cmd_write_q;
                    state_d   = ADVANCE;
                end
            end
            ADVANCE: state_d = SETTLE;
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        sdram_full_d = (rows_d == ROWS_W'(MAX_ROWS));
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            cmd_valid_q  <= 1'b0;
            cmd_write_q  <= 1'b0;
            cmd_bank_q   <= 2'd0;
            cmd_row_q    <= 13'd0;
            incr_wr_q    <= 1'b0;
            incr_rd_q    <= 1'b0;
            rows_q       <= '0;
            sdram_full_q <= 1'b0;
            last_wr_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_write_q  <= cmd_write_d;
            cmd_bank_q   <= cmd_bank_d;
            cmd_row_q    <= cmd_row_d;
            incr_wr_q    <= incr_wr_d;
            incr_rd_q    <= incr_rd_d;
            rows_q       <= rows_d;
            sdram_full_q <= sdram_full_d;
            last_wr_q    <= last_wr_d;
            busy_q       <= busy_d;
        end
    end

    assign cmd_if.cmd_valid = cmd_valid_q;
    assign cmd_if.cmd_write = cmd_write_q;
    assign cmd_if.cmd_bank  = cmd_bank_q;
    assign cmd_if.cmd_row   = cmd_row_q;
    assign incr_wr_ptr      = incr_wr_q;
    assign incr_rd_ptr      = incr_rd_q;
    assign sdram_full       = sdram_full_q;
    assign rows_stored      = rows_q;
    assign busy             = busy_q;
endmodule

// File: tb/tb_row_stream_scheduler.sv
// Bench for row_stream_scheduler: pointer-block and controller models, command scoreboard,
// a decision vector table and hand-written multi-cycle sequences.
module tb_row_stream_scheduler;
    localparam int unsigned MAX_ROWS = 6;
    localparam logic [14:0] PTR_MAX  = 15'd32767;

    typedef struct packed {
        logic        w;
        logic [1:0]  bank;
        logic [12:0] row;
    } cmd_t;

    typedef struct {
        logic [10:0] lvl;
        logic [10:0] free;
        logic        refr;
        int          budget;
        bit          exp_cmd;
    } vec_t;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [10:0] in_level, out_free;
    logic        refresh_req;
    logic        sdram_empty;
    logic [12:0] wr_row, rd_row;
    logic [1:0]  wr_bank, rd_bank;
    logic        incr_wr_ptr, incr_rd_ptr, sdram_full, busy;
    logic [14:0] rows_stored;
    logic [14:0] wr_ptr, rd_ptr;
    logic        rsp_ready, rsp_done, man_ready, man_done;
    bit          ctrl_en;
    int          ready_dly, done_dly;
    int          checks = 0, failures = 0;
    int          acc_cnt = 0, wr_pulses = 0, rd_pulses = 0;
    cmd_t        sb_q[$];
    logic [14:0] pw, pr;
    vec_t        vecs[7];

    row_stream_scheduler_if cmd_if();
    assign cmd_if.cmd_ready = rsp_ready | man_ready;
    assign cmd_if.cmd_done  = rsp_done | man_done;

    row_stream_scheduler #(.ROW_WORDS(512), .LEVEL_W(11), .MAX_ROWS(MAX_ROWS)) dut (
        .clk(clk), .n_rst(n_rst), .in_level(in_level), .out_free(out_free),
        .refresh_req(refresh_req), .sdram_empty(sdram_empty),
        .wr_row(wr_row), .wr_bank(wr_bank), .rd_row(rd_row), .rd_bank(rd_bank),
        .cmd_if(cmd_if), .incr_wr_ptr(incr_wr_ptr), .incr_rd_ptr(incr_rd_ptr),
        .sdram_full(sdram_full), .rows_stored(rows_stored), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] ptr_inc(input logic [14:0] p);
        return (p == PTR_MAX) ? 15'd0 : p + 15'd1;
    endfunction

    // Pointer block model: ptr = {row, bank}
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (incr_wr_ptr) wr_ptr <= ptr_inc(wr_ptr);
            if (incr_rd_ptr) rd_ptr <= ptr_inc(rd_ptr);
        end
    end
    assign sdram_empty = (wr_ptr == rd_ptr);
    assign wr_row  = wr_ptr[14:2];
    assign wr_bank = wr_ptr[1:0];
    assign rd_row  = rd_ptr[14:2];
    assign rd_bank = rd_ptr[1:0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_cmd(input bit w);
        cmd_t c;
        c.w = w;
        if (w) begin c.bank = pw[1:0]; c.row = pw[14:2]; pw = ptr_inc(pw); end
        else   begin c.bank = pr[1:0]; c.row = pr[14:2]; pr = ptr_inc(pr); end
        sb_q.push_back(c);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [10:0] lvl, input logic [10:0] free);
        tick();
        in_level = lvl;
        out_free = free;
    endtask

    task automatic wait_rows(input logic [14:0] target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rows_stored == target) return;
        end
        checks++;
        failures++;
        $display("FAIL wait_rows timeout rows=%0d expected=%0d", rows_stored, target);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !busy && !cmd_if.cmd_valid) return;
        end
        checks++;
        failures++;
        $display("FAIL drain timeout pending=%0d busy=%0b expected pending=0 busy=0", sb_q.size(), busy);
    endtask

    task automatic run_until_acc(input int n, input int budget);
        int target;
        target = acc_cnt + n;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (acc_cnt >= target) return;
        end
        checks++;
        failures++;
        $display("FAIL accept timeout accepted=%0d expected=%0d", acc_cnt, target);
    endtask

    task automatic count_valid(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (cmd_if.cmd_valid) seen++;
        end
    endtask

    // Controller model: accepts after ready_dly cycles, pulses cmd_done done_dly cycles later
    initial begin
        rsp_ready = 1'b0;
        rsp_done  = 1'b0;
        forever begin
            tick();
            if (ctrl_en && n_rst && cmd_if.cmd_valid) begin
                repeat (ready_dly) tick();
                rsp_ready = 1'b1;
                tick();
                rsp_ready = 1'b0;
                repeat (done_dly) tick();
                rsp_done = 1'b1;
                tick();
                rsp_done = 1'b0;
            end
        end
    end

    // Monitor: scoreboard on acceptance, command hold stability, single-cycle incr pulses
    initial begin
        cmd_t cur, prev, exp;
        bit   held, pwr, prd;
        held = 0; pwr = 0; prd = 0; prev = '0;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                held = 0; pwr = 0; prd = 0;
                continue;
            end
            cur = {cmd_if.cmd_write, cmd_if.cmd_bank, cmd_if.cmd_row};
            if (held) begin
                check("hold_valid", 32'(cmd_if.cmd_valid), 32'd1);
                check("hold_fields", 32'(cur), 32'(prev));
            end
            if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
                acc_cnt++;
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_cmd actual=%0h expected=none", cur);
                end else begin
                    exp = sb_q.pop_front();
                    check("sb_cmd", 32'(cur), 32'(exp));
                end
            end
            held = cmd_if.cmd_valid && !cmd_if.cmd_ready;
            prev = cur;
            if (incr_wr_ptr) begin check("incr_wr_width", 32'(pwr), 32'd0); wr_pulses++; end
            if (incr_rd_ptr) begin check("incr_rd_width", 32'(prd), 32'd0); rd_pulses++; end
            if (incr_wr_ptr && incr_rd_ptr) check("incr_both", 32'd1, 32'd0);
            pwr = incr_wr_ptr;
            prd = incr_rd_ptr;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bit found;
        int seen, snap_w, snap_r;

        vecs[0] = '{11'd511,  11'd2047, 1'b0, 100, 1'b0};
        vecs[1] = '{11'd1024, 11'd0,    1'b1, 30,  1'b0};
        vecs[2] = '{11'd0,    11'd512,  1'b0, 30,  1'b0};
        vecs[3] = '{11'd512,  11'd0,    1'b0, 30,  1'b1};
        vecs[4] = '{11'd2047, 11'd2047, 1'b0, 30,  1'b1};
        vecs[5] = '{11'd512,  11'd511,  1'b0, 30,  1'b1};
        vecs[6] = '{11'd0,    11'd0,    1'b0, 30,  1'b0};

        n_rst = 1'b0; in_level = 11'd512; out_free = 11'd0; refresh_req = 1'b0;
        man_ready = 1'b0; man_done = 1'b0; ctrl_en = 1'b1; ready_dly = 3; done_dly = 10;
        pw = '0; pr = '0;

        // Reset values and the first write
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(cmd_if.cmd_valid), 32'd0);
        check("rst_cmd", 32'({cmd_if.cmd_write, cmd_if.cmd_bank, cmd_if.cmd_row}), 32'd0);
        check("rst_incr", 32'({incr_wr_ptr, incr_rd_ptr}), 32'd0);
        check("rst_rows", 32'(rows_stored), 32'd0);
        check("rst_full_busy", 32'({sdram_full, busy}), 32'd0);
        push_cmd(1'b1);
        tick();
        n_rst = 1'b1;
        @(negedge clk);
        check("first_valid_early", 32'(cmd_if.cmd_valid), 32'd0);
        @(negedge clk);
        check("first_valid", 32'(cmd_if.cmd_valid), 32'd1);
        check("first_write", 32'(cmd_if.cmd_write), 32'd1);
        check("first_busy", 32'(busy), 32'd1);
        tick();
        in_level = 11'd0;
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            found = incr_wr_ptr;
        end
        check("first_incr_seen", 32'(found), 32'd1);
        check("first_rows", 32'(rows_stored), 32'd1);
        @(negedge clk);
        check("first_incr_low", 32'(incr_wr_ptr), 32'd0);
        wait_drain(100);
        push_cmd(1'b0);
        set_in(11'd0, 11'd512);
        wait_rows(15'd0, 100);
        set_in(11'd0, 11'd0);
        wait_drain(100);

        // Decision table, starting from empty SDRAM
        ready_dly = 1; done_dly = 2;
        foreach (vecs[i]) begin
            found = 0;
            if (vecs[i].exp_cmd) push_cmd(1'b1);
            tick();
            in_level = vecs[i].lvl; out_free = vecs[i].free; refresh_req = vecs[i].refr;
            for (int c = 0; c < vecs[i].budget && !found; c++) begin
                @(negedge clk);
                found = cmd_if.cmd_valid;
            end
            check($sformatf("vec%0d_cmd", i), 32'(found), 32'(vecs[i].exp_cmd));
            if (!found) check($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
            tick();
            in_level = 11'd0; out_free = 11'd0; refresh_req = 1'b0;
            wait_drain(100);
            check($sformatf("vec%0d_rows", i), 32'(rows_stored), 32'(vecs[i].exp_cmd));
            if (rows_stored != 15'd0) begin
                push_cmd(1'b0);
                set_in(11'd0, 11'd512);
                wait_rows(15'd0, 100);
                set_in(11'd0, 11'd0);
                wait_drain(100);
            end
        end

        // Both eligible from empty: W,R,W,R,W,R
        ready_dly = 0; done_dly = 0;
        for (int k = 0; k < 6; k++) push_cmd((k % 2) == 0);
        set_in(11'd1024, 11'd1024);
        run_until_acc(6, 300);
        set_in(11'd0, 11'd0);
        wait_drain(100);
        check("alt_a_rows", 32'(rows_stored), 32'd0);

        // Two rows stored, last op write: tie starts with read
        push_cmd(1'b1); push_cmd(1'b1);
        set_in(11'd1024, 11'd0);
        run_until_acc(2, 100);
        push_cmd(1'b0); push_cmd(1'b1); push_cmd(1'b0); push_cmd(1'b1);
        set_in(11'd1024, 11'd1024);
        run_until_acc(4, 200);
        set_in(11'd0, 11'd0);
        wait_drain(100);
        check("alt_b_rows", 32'(rows_stored), 32'd2);
        push_cmd(1'b0); push_cmd(1'b0);
        set_in(11'd0, 11'd512);
        wait_rows(15'd0, 100);
        set_in(11'd0, 11'd0);
        wait_drain(100);

        // Refresh blocks IDLE decisions but not an in-flight burst
        ready_dly = 1; done_dly = 10;
        tick();
        refresh_req = 1'b1; in_level = 11'd1024;
        count_valid(20, seen);
        check("refresh_hold_valid", 32'(seen), 32'd0);
        check("refresh_hold_busy", 32'(busy), 32'd0);
        push_cmd(1'b1);
        snap_w = wr_pulses;
        tick();
        refresh_req = 1'b0;
        @(negedge clk);
        check("refresh_release_early", 32'(cmd_if.cmd_valid), 32'd0);
        @(negedge clk);
        check("refresh_release_valid", 32'(cmd_if.cmd_valid), 32'd1);
        run_until_acc(1, 50);
        tick();
        refresh_req = 1'b1;
        wait_rows(15'd1, 50);
        check("refresh_wait_done_pulse", 32'(wr_pulses - snap_w), 32'd1);
        count_valid(20, seen);
        check("refresh_reblock", 32'(seen), 32'd0);
        tick();
        in_level = 11'd0; refresh_req = 1'b0;
        push_cmd(1'b0);
        set_in(11'd0, 11'd512);
        wait_rows(15'd0, 100);
        set_in(11'd0, 11'd0);
        wait_drain(100);

        // Full boundary: write allowed at MAX_ROWS-1, then reads only
        ready_dly = 0; done_dly = 1;
        for (int k = 0; k < MAX_ROWS - 1; k++) push_cmd(1'b1);
        set_in(11'd2047, 11'd0);
        wait_rows(15'(MAX_ROWS - 1), 300);
        set_in(11'd0, 11'd0);
        wait_drain(100);
        check("full_below_flag", 32'(sdram_full), 32'd0);
        check("full_below_rows", 32'(rows_stored), 32'(MAX_ROWS - 1));
        push_cmd(1'b1);
        set_in(11'd2047, 11'd0);
        wait_rows(15'(MAX_ROWS), 100);
        check("full_flag_set", 32'(sdram_full), 32'd1);
        count_valid(30, seen);
        check("full_no_write", 32'(seen), 32'd0);
        check("full_idle_busy", 32'(busy), 32'd0);
        push_cmd(1'b0);
        set_in(11'd2047, 11'd512);
        wait_rows(15'(MAX_ROWS - 1), 100);
        check("full_flag_clear", 32'(sdram_full), 32'd0);
        set_in(11'd0, 11'd0);
        wait_drain(100);
        check("full_after_read_rows", 32'(rows_stored), 32'(MAX_ROWS - 1));

        // Reset during WAIT_DONE, then a late cmd_done
        ctrl_en = 1'b0;
        push_cmd(1'b1);
        set_in(11'd512, 11'd0);
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            found = cmd_if.cmd_valid;
        end
        check("rst_mid_cmd_seen", 32'(found), 32'd1);
        tick();
        man_ready = 1'b1;
        tick();
        man_ready = 1'b0;
        repeat (3) tick();
        n_rst = 1'b0; in_level = 11'd0;
        pw = '0; pr = '0;
        snap_w = wr_pulses; snap_r = rd_pulses;
        @(negedge clk);
        check("rst_mid_valid", 32'(cmd_if.cmd_valid), 32'd0);
        check("rst_mid_rows", 32'(rows_stored), 32'd0);
        check("rst_mid_full_busy", 32'({sdram_full, busy}), 32'd0);
        tick();
        n_rst = 1'b1;
        tick();
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        repeat (10) @(negedge clk);
        check("late_done_no_wr", 32'(wr_pulses - snap_w), 32'd0);
        check("late_done_no_rd", 32'(rd_pulses - snap_r), 32'd0);
        check("late_done_rows", 32'(rows_stored), 32'd0);
        check("late_done_busy", 32'({busy, cmd_if.cmd_valid}), 32'd0);

        // Normal operation resumes from pointer 0
        ctrl_en = 1'b1;
        push_cmd(1'b1);
        set_in(11'd512, 11'd0);
        wait_rows(15'd1, 100);
        set_in(11'd0, 11'd0);
        wait_drain(100);
        check("post_rst_rows", 32'(rows_stored), 32'd1);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/row_stream_scheduler.md
Name: row_stream_scheduler

Overview:
- Clocked scheduler between the ingress/egress stream FIFOs, the SDRAM controller and the row/bank ring-pointer block.
- Decides when a full row is burst-written to SDRAM or burst-read back, and issues one row command at a time to the controller.
- Emits registered single-cycle increment pulses to the pointer block and tracks SDRAM row occupancy, which provides the full flag.

Parameters:
ROW_WORDS, 512, words per row burst; the threshold for FIFO level and free space.
LEVEL_W, 11, width of the in_level and out_free FIFO counts.
MAX_ROWS, 32767, occupancy at which SDRAM is full; one of 2^15 rows stays unused so that equal pointers mean empty.

Ports:
clk  in  1  system clock, all state on rising edge
n_rst  in  1  reset, asynchronous, active-low
in_level  in  LEVEL_W  words held in ingress FIFO
out_free  in  LEVEL_W  free words in egress FIFO
refresh_req  in  1  controller refresh pending; blocks new commands
sdram_empty  in  1  from pointer block, wr_ptr==rd_ptr
wr_row  in  13  current write row from pointer block
wr_bank  in  2  current write bank
rd_row  in  13  current read row
rd_bank  in  2  current read bank
cmd_valid  out  1  row command offered to controller
cmd_ready  in  1  controller accepts command when high with cmd_valid
cmd_write  out  1  1=write burst, 0=read burst
cmd_bank  out  2  bank of command
cmd_row  out  13  row of command
cmd_done  in  1  one-cycle pulse, burst finished
incr_wr_ptr  out  1  registered pulse, advances write pointer
incr_rd_ptr  out  1  registered pulse, advances read pointer
sdram_full  out  1  rows_stored == MAX_ROWS
rows_stored  out  15  rows currently held in SDRAM
busy  out  1  state != IDLE

Behaviour:
- Reset (async, n_rst=0): state IDLE, cmd_valid=0, cmd_write=0, cmd_bank=0, cmd_row=0, incr_wr_ptr=0, incr_rd_ptr=0, rows_stored=0, sdram_full=0, last_op=read (so write wins first tie), busy=0. The pointer block shares n_rst, so the two stay consistent on reset mid-operation. Any in-flight burst is abandoned with no pointer increment.
- FSM states: IDLE, ISSUE, WAIT_DONE, ADVANCE, SETTLE.
- IDLE:
  - wr_ok = in_level >= ROW_WORDS and !sdram_full.
  - rd_ok = out_free >= ROW_WORDS and !sdram_empty.
  - If refresh_req=1: stay in IDLE.
  - If only one of wr_ok/rd_ok: select it. If both: select the opposite of last_op (round-robin).
  - On a selection: latch cmd_write, plus cmd_bank/cmd_row from wr_* or rd_*. Go to ISSUE. cmd_valid=1 from the next cycle.
- ISSUE: hold cmd_valid=1 with cmd_write/cmd_bank/cmd_row stable until cmd_ready=1. On the accepting cycle, go to WAIT_DONE and drop cmd_valid the next cycle. refresh_req is ignored once in ISSUE.
- WAIT_DONE: wait for cmd_done. The controller guarantees cmd_done no earlier than the cycle after acceptance. cmd_done in any other state is ignored.
- ADVANCE (exactly 1 cycle):
  - incr_wr_ptr=1 (write) or incr_rd_ptr=1 (read).
  - rows_stored +1 (write) or -1 (read); last_op updated.
- SETTLE (exactly 1 cycle): both incr outputs 0, so the pointer block sees exactly one rising edge per row. This allows pointers and sdram_empty to settle before the next IDLE decision. Then go to IDLE.
- Latency: IDLE decision to cmd_valid = 1 cycle. cmd_done to incr pulse = 1 cycle. Minimum IDLE-to-IDLE loop = 5 cycles plus controller time.
- Arithmetic:
  - rows_stored never wraps: a write only occurs when rows_stored < MAX_ROWS, a read only when !sdram_empty.
  - sdram_full is registered, updated with rows_stored.
  - Pointers wrap 32767->0 inside the pointer block; the scheduler only forwards row/bank values.
- Boundaries:
  - At rows_stored = MAX_ROWS-1 a write is still allowed; afterwards sdram_full=1 and only reads proceed.
  - Empty: writes only.
  - Both FIFOs idle: stay in IDLE, all outputs static.

Test Plan:
- Reset release, in_level=512, out_free=0 -> cmd_valid=1 one cycle after IDLE with cmd_write=1, bank 0, row 0. cmd_ready after 3 cycles, cmd_done after 10 -> incr_wr_ptr high exactly 1 cycle, rows_stored=1.
- in_level=511, out_free=2047, sdram_empty=1 -> no command for 100 cycles, busy=0.
- Both eligible for 6 consecutive rows -> command order W,R,W,R,W,R, i.e. strict alternation starting with write.
- refresh_req=1 while in IDLE with in_level=1024 -> no cmd_valid. Deassert -> command issued 1 cycle later. refresh_req raised during WAIT_DONE -> burst completes normally.
- Preload rows_stored=32766, in_level=2047, out_free=0 -> one write, sdram_full=1, no further writes. Then out_free=512 -> read issued, sdram_full=0.
- n_rst pulsed low during WAIT_DONE -> cmd_valid=0, incr pulses never asserted, rows_stored=0. A late cmd_done after reset is ignored.
